// File: rtl/seq_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : seq_addsub
//  Purpose  : Multi-cycle WIDTH-bit adder/subtractor. One SLICE-bit slice is
//             added per clock, LSB slice first, so the critical path is a
//             single SLICE-bit adder. A start/busy/done handshake frames each
//             operation; carry-out, signed-overflow and zero flags are
//             produced with the result.
//  Ports    : clk    - clock, rising edge
//             rst_n  - asynchronous active-low reset
//             start  - operation request (accepted in IDLE or DONE only)
//             sub    - 0: a + b + cin, 1: a + ~b + cin
//             a, b   - operands, captured on an accepted start
//             cin    - carry into slice 0, captured on an accepted start
//             busy   - high while slices are being processed
//             done   - one-cycle pulse when results become valid
//             sum    - result, held until the next accepted start
//             cout   - carry out of the MSB
//             ov     - signed overflow
//             zero   - final sum equals zero
//             sat    - result was saturated (0 when saturation is disabled)
//  Options  : define SEQ_ADDSUB_SAT_EN to clamp overflowing results to the
//             signed limit of the operand sign.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ov,
    output logic             zero,
    output logic             sat
);

    localparam int c_num_slices = WIDTH / SLICE;
    localparam int c_cnt_w      = (c_num_slices > 1) ? $clog2(c_num_slices) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_num_slices - 1);

    generate
        if ((WIDTH % SLICE) != 0 || c_num_slices < 1) begin : g_param_check
            $error("seq_addsub: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;      // already inverted for subtraction
    logic                 r_carry;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_cout;
    logic                 r_ov;
    logic                 r_zero;

    logic                 w_accept;
    logic                 w_last;
    logic [SLICE-1:0]     w_a_sl;
    logic [SLICE-1:0]     w_b_sl;
    logic [SLICE:0]       w_add;
    logic [WIDTH-1:0]     w_sum_next;
    logic [WIDTH-1:0]     w_final;
    logic                 w_ov;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_last   = (r_state == ST_RUN) && (r_cnt == c_last);

    // ------------------------------------------------------------------------
    // Slice adder
    // ------------------------------------------------------------------------
    assign w_a_sl = r_a[r_cnt*SLICE +: SLICE];
    assign w_b_sl = r_b[r_cnt*SLICE +: SLICE];
    assign w_add  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_carry};

    // The sum register is updated in place; earlier slices are already final.
    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[r_cnt*SLICE +: SLICE] = w_add[SLICE-1:0];
    end

    // Carry into the MSB equals a ^ b ^ sum at that bit, so overflow is that
    // XOR combined with the carry out. Only meaningful on the last slice.
    assign w_ov = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum_next[WIDTH-1] ^ w_add[SLICE];

`ifdef SEQ_ADDSUB_SAT_EN
    logic             r_sat;
    logic             w_sat;
    logic [WIDTH-1:0] w_sat_val;

    // Both operand signs clear means the true result overflowed upwards.
    assign w_sat_val = (!r_a[WIDTH-1] && !r_b[WIDTH-1]) ? {1'b0, {(WIDTH-1){1'b1}}}
                                                       : {1'b1, {(WIDTH-1){1'b0}}};
    assign w_sat     = w_last && w_ov;
    assign w_final   = w_sat ? w_sat_val : w_sum_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_sat <= 1'b0;
        end else if (w_last) begin
            r_sat <= w_sat;
        end
    end

    assign sat = r_sat;
`else
    assign w_final = w_sum_next;
    assign sat     = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ov    <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ov    <= 1'b0;
            r_zero  <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_sum   <= w_final;
            r_carry <= w_add[SLICE];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_add[SLICE];
                r_ov   <= w_ov;
                r_zero <= (w_final == '0);
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ov   = r_ov;
    assign zero = r_zero;

endmodule
`default_nettype wire

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the fixed 8-bit ripple adder.
- Computes a WIDTH-bit sum or difference one SLICE-bit slice per clock, LSB slice first, through a start/busy/done handshake.
- Produces carry-out, signed-overflow and zero flags.
- Used where a wide single-cycle ripple chain would break timing; trades latency for a short critical path of one SLICE-bit adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of SLICE.
SLICE, 4, bits added per clock; number of slices N = WIDTH/SLICE, N >= 1.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
sub  input  1  0: a + b + cin; 1: a + ~b + cin (cin=1 gives a - b)
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in to slice 0, captured on accepted start
busy  output  1  high while slices are being processed
done  output  1  one-cycle pulse when results become valid
sum  output  WIDTH  result, held until next accepted start
cout  output  1  carry out of MSB
ov  output  1  signed overflow (carry into MSB XOR carry out of MSB)
zero  output  1  high when sum == 0
sat  output  1  saturation occurred (see Optional Feature); 0 otherwise

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, sum=0, cout=0, ov=0, zero=0, sat=0; slice counter=0; internal operand registers cleared.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1: capture a, (sub ? ~b : b), cin into internal registers; carry register = cin; counter=0; go to RUN; busy=1 next cycle; done=0.
- RUN, each cycle: add slice[counter] of A and B' plus carry register; write the SLICE result bits into sum[counter*SLICE +: SLICE]; update the carry register.
  - On the last slice (counter = N-1): record carry into MSB for ov; set cout and zero; go to DONE; busy=0; done=1 for exactly one cycle.
- sum, cout, ov and zero are undefined for consumers while busy=1; the sum register may be written in place.
- Latency: start accepted at edge T → done high in the cycle after edge T+N. A back-to-back start in DONE is accepted, giving throughput of one result per N+1 cycles.
- start while busy=1 is ignored; it is not queued and the in-flight operation is unaffected.
- DONE with no start: go to IDLE after one cycle. Results stay held in IDLE.
- Changes to a, b, sub or cin after capture have no effect on the in-flight operation.
- N=1: single RUN cycle; done follows accepted start by 2 edges.
- Reset asserted mid-RUN: operation aborted; all outputs return to reset values immediately; no done pulse.
- Arithmetic is modulo 2^WIDTH. zero reflects the final sum (after saturation if enabled).

Optional Feature:
- Macro: SEQ_ADDSUB_SAT_EN.
- Defined: on completion, if ov=1, sum is replaced by the signed saturation limit in the same cycle done rises, and sat=1 with done.
  - Positive limit 0x7F..F when the operand sign bits (A and B') are both 0.
  - Negative limit 0x80..0 otherwise.
  - cout and ov still report the raw result. sat is held with the results and cleared on the next accepted start.
- Undefined: no saturation logic; sum is the raw wrapped result; sat is tied 0.

Test Plan:
- WIDTH=16, SLICE=4: a=0x1234, b=0x0FED, sub=0, cin=0, start → busy 4 cycles; done pulse; sum=0x2221, cout=0, ov=0, zero=0.
- a=0xFFFF, b=0x0001, sub=0, cin=0 → sum=0x0000, cout=1, ov=0, zero=1.
- a=0x7FFF, b=0x0001, sub=0, cin=0 → sum=0x8000, ov=1, cout=0. With SEQ_ADDSUB_SAT_EN: sum=0x7FFF, sat=1.
- a=0x0005, b=0x0007, sub=1, cin=1 → sum=0xFFFE, cout=0, ov=0. Repeat with a=0x8000, b=0x0001 → sum=0x7FFF, ov=1 (with macro: sum=0x8000, sat=1).
- Assert start again on cycle 2 of RUN with different operands → ignored; result matches the first operands. Then start in the DONE cycle → accepted; second result after a further 4 cycles.
- Drop rst_n in the 3rd RUN cycle → busy, done, sum and flags all 0 asynchronously; no done pulse. After release, a fresh start completes normally.
